// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} arb_state_e;
  localparam int MAX_BURST = 16;
  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction
  // Wraps on an explicit compare so non-power-of-2 N stays correct.
  function automatic logic [7:0] inc_mod(input logic [7:0] v, input int n);
    return (v == 8'(n - 1)) ? 8'd0 : v + 8'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, nearest set bit at or after ptr_i (mod N).
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);
  always_comb begin
    int best;
    int d;
    found_o = 1'b0;
    idx_o   = '0;
    best    = N;
    d       = 0;
    for (int j = 0; j < N; j++) begin
      d = (j >= int'(ptr_i)) ? j - int'(ptr_i) : j + N - int'(ptr_i);
      if (req_i[j] && d < best) begin
        best    = d;
        found_o = 1'b1;
        idx_o   = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the FIFO write port among N requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int IDW   = 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*DSIZE-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ready,
  input  logic               full,
  output logic               winc,
  output logic [DSIZE-1:0]   wdata,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id
);
  localparam int CW = cnt_w(BURST);

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic           found, cur_valid, cur_last, acc, rel;
  logic [IDW-1:0] pick_idx;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .found_o(found),
    .idx_o  (pick_idx)
  );

  // Write strobe is purely combinational so full gates it in the same cycle.
  assign cur_valid = req_valid[gnt_id_q];
  assign cur_last  = req_last[gnt_id_q];
  assign acc       = (state_q == ST_BURST) && cur_valid && !full;
  assign rel       = !cur_valid || (acc && (cur_last || cnt_q == CW'(BURST - 1)));
  assign winc      = acc;
  assign wdata     = req_data[gnt_id_q*DSIZE +: DSIZE];
  assign req_ready = acc ? (N'(1) << gnt_id_q) : '0;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d     = ST_BURST;
        gnt_id_d    = pick_idx;
        gnt_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if (rel) begin
      state_d     = ST_IDLE;
      gnt_valid_d = 1'b0;
      cnt_d       = '0;
      rr_ptr_d    = IDW'(inc_mod(8'(gnt_id_q), N));
    end else begin
      cnt_d = acc ? cnt_q + CW'(1) : cnt_q;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with queue-backed requesters and an 8-deep FIFO model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DSIZE = 8, BURST = 4, IDW = 2;

  logic               wclk = 1'b0;
  logic               wrst_n;
  logic [N-1:0]       req_valid, req_last, req_ready;
  logic [N*DSIZE-1:0] req_data;
  logic               full, winc, gnt_valid;
  logic [DSIZE-1:0]   wdata;
  logic [IDW-1:0]     gnt_id;

  fifo_wr_arbiter #(.N(N), .DSIZE(DSIZE), .BURST(BURST), .IDW(IDW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full(full), .winc(winc),
    .wdata(wdata), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  always #5 wclk = ~wclk;

  logic [8:0]       src[N][$];
  logic [7:0]       ff[$], wlog[$], rdlog[$], gfirst[$];
  logic [1:0]       glog[$];
  int               gcnt[$];
  int               tests = 0, fails = 0;
  int               cyc, viol, rdy_cnt, first_wr, last_wr;
  logic [31:0]      wmask;
  logic             rd_en, gv_prev;
  logic             s_w, s_gv, s_full;
  logic [7:0]       s_d;
  logic [N-1:0]     s_rdy;
  logic [IDW-1:0]   s_gi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk8(input logic [7:0] q[$]);
    logic [63:0] v = '0;
    foreach (q[k]) v = (v << 8) | 64'(q[k]);
    return v;
  endfunction

  function automatic logic [63:0] pkg4(input logic [1:0] q[$]);
    logic [63:0] v = '0;
    foreach (q[k]) v = (v << 4) | 64'(q[k]);
    return v;
  endfunction

  function automatic logic [63:0] pkc(input int q[$]);
    logic [63:0] v = '0;
    foreach (q[k]) v = (v << 4) | 64'(q[k] & 15);
    return v;
  endfunction

  function automatic bit any_src();
    for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = src[i].size() > 0;
      req_data[i*DSIZE +: DSIZE] = (src[i].size() > 0) ? src[i][0][7:0] : 8'h00;
      req_last[i]               = (src[i].size() > 0) ? src[i][0][8] : 1'b0;
    end
    full = ff.size() >= 8;
  endtask

  task automatic clear_logs();
    wlog.delete(); rdlog.delete(); gfirst.delete(); glog.delete(); gcnt.delete();
    cyc = 0; wmask = '0; first_wr = -1; last_wr = -1; rdy_cnt = 0; gv_prev = gnt_valid;
  endtask

  // Sample away from the edge, then apply the accepted handshakes just after it.
  task automatic cycle();
    @(negedge wclk);
    s_w = winc; s_d = wdata; s_rdy = req_ready; s_gv = gnt_valid; s_gi = gnt_id; s_full = full;
    if (s_w && s_full) viol++;
    if (s_rdy != '0) rdy_cnt++;
    if (s_gv && !gv_prev) begin
      glog.push_back(s_gi);
      gcnt.push_back(0);
    end
    gv_prev = s_gv;
    if (s_w) begin
      if (gcnt.size() > 0) begin
        if (gcnt[gcnt.size()-1] == 0) gfirst.push_back(s_d);
        gcnt[gcnt.size()-1] = gcnt[gcnt.size()-1] + 1;
      end
      wlog.push_back(s_d);
      if (cyc < 32) wmask = wmask | (32'd1 << cyc);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    @(posedge wclk);
    #1;
    if (rd_en && ff.size() > 0) rdlog.push_back(ff.pop_front());
    if (s_w) ff.push_back(s_d);
    for (int i = 0; i < N; i++) if (s_rdy[i]) void'(src[i].pop_front());
    cyc++;
    drive();
  endtask

  task automatic run_until(input string tag, input int max);
    int n = 0;
    while (any_src() && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_tmo"}, 64'(any_src()), 64'd0);
  endtask

  initial begin
    int bad;
    wrst_n = 1'b0; rd_en = 1'b1; viol = 0;
    drive();
    clear_logs();
    repeat (3) cycle();
    chk("rst_gv", 64'(gnt_valid), 0);
    chk("rst_winc", 64'(winc), 0);
    chk("rst_rdy", 64'(req_ready), 0);
    chk("rst_gid", 64'(gnt_id), 0);
    wrst_n = 1'b1;
    clear_logs();
    repeat (10) cycle();
    chk("idle_writes", 64'(wlog.size()), 0);
    chk("idle_grants", 64'(glog.size()), 0);
    chk("idle_rdy", 64'(rdy_cnt), 0);

    // Req 2 alone, six words, no last
    clear_logs();
    for (int k = 0; k < 6; k++) src[2].push_back({1'b0, 8'(8'hA0 + k)});
    drive();
    run_until("t1", 40);
    repeat (3) cycle();
    chk("t1_data", pk8(wlog), 64'hA0A1A2A3A4A5);
    chk("t1_mask", 64'(wmask), 64'hDE);
    chk("t1_grants", pkg4(glog), 64'h22);
    chk("t1_cnts", pkc(gcnt), 64'h42);
    chk("t1_read", pk8(rdlog), 64'hA0A1A2A3A4A5);

    // Reqs 0,1,3 streaming; pointer sits at 3 after the previous release
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      src[0].push_back({1'b0, 8'(8'h00 + k)});
      src[1].push_back({1'b0, 8'(8'h10 + k)});
      src[3].push_back({1'b0, 8'(8'h30 + k)});
    end
    drive();
    run_until("t2", 80);
    repeat (3) cycle();
    chk("t2_grants", pkg4(glog), 64'h301301);
    chk("t2_cnts", pkc(gcnt), 64'h444444);
    chk("t2_firsts", pk8(gfirst), 64'h300010340414);
    chk("t2_nwr", 64'(wlog.size()), 24);
    chk("t2_first_wr", 64'(first_wr), 1);
    chk("t2_last_wr", 64'(last_wr), 29);

    // Req 1 short packet with last; 3 and 0 queue up behind it
    clear_logs();
    src[1].push_back({1'b0, 8'hB0});
    src[1].push_back({1'b1, 8'hB1});
    drive();
    cycle();
    src[0].push_back({1'b1, 8'hC0});
    src[3].push_back({1'b1, 8'hC3});
    drive();
    run_until("t3", 40);
    repeat (3) cycle();
    chk("t3_grants", pkg4(glog), 64'h130);
    chk("t3_cnts", pkc(gcnt), 64'h211);
    chk("t3_data", pk8(wlog), 64'hB0B1C3C0);

    // Reader stopped: FIFO fills at 8 and the grant stalls
    for (int n = 0; n < 20 && ff.size() > 0; n++) cycle();
    clear_logs();
    rd_en = 1'b0;
    for (int k = 0; k < 12; k++) src[0].push_back({1'b0, 8'(8'hD0 + k)});
    drive();
    repeat (30) cycle();
    chk("t4_nwr", 64'(wlog.size()), 8);
    chk("t4_full", 64'(s_full), 1);
    chk("t4_gv", 64'(s_gv), 1);
    chk("t4_gid", 64'(s_gi), 0);
    chk("t4_winc", 64'(s_w), 0);
    chk("t4_rdy", 64'(s_rdy), 0);
    chk("t4_pending", 64'(src[0].size()), 4);
    rd_en = 1'b1;
    run_until("t4", 40);
    for (int n = 0; n < 30 && ff.size() > 0; n++) cycle();
    chk("t4_nread", 64'(rdlog.size()), 12);
    bad = 0;
    foreach (rdlog[k]) if (rdlog[k] !== 8'(8'hD0 + k)) bad++;
    chk("t4_order", 64'(bad), 0);
    chk("t4_cnts", pkc(gcnt), 64'h444);

    // Asynchronous reset in the middle of a burst
    clear_logs();
    for (int k = 0; k < 4; k++) src[1].push_back({1'b0, 8'(8'hE0 + k)});
    drive();
    repeat (3) cycle();
    chk("t5_pre_nwr", 64'(wlog.size()), 2);
    chk("t5_pre_winc", 64'(winc), 1);
    wrst_n = 1'b0;
    #1;
    chk("t5_rst_winc", 64'(winc), 0);
    chk("t5_rst_rdy", 64'(req_ready), 0);
    chk("t5_rst_gv", 64'(gnt_valid), 0);
    chk("t5_rst_gid", 64'(gnt_id), 0);
    src[0].push_back({1'b1, 8'hF0});
    drive();
    repeat (2) cycle();
    clear_logs();
    wrst_n = 1'b1;
    run_until("t5", 40);
    repeat (3) cycle();
    chk("t5_grants", pkg4(glog), 64'h01);
    chk("t5_data", pk8(wlog), 64'hF0E2E3);

    chk("no_write_full", 64'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the dual-clock FIFO (winc/wdata/full) between N requesters in the write-clock domain.
- Grants one requester at a time for a bounded burst, ended early by a last flag or by the requester dropping valid.
- Drives FIFO winc combinationally from the grant state, so no word is ever accepted while full.
- Sits directly in front of fifo, on wclk/wrst_n.

Parameters:
- N, 4, number of requesters (2..8).
- DSIZE, 8, data width, equal to the FIFO DSIZE.
- BURST, 4, max words per grant (1..16).
- IDW, 2, grant index width, equal to clog2(N).

Ports:
- wclk  input  1  write-domain clock; all state updates on posedge.
- wrst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  N  requester i has a word.
- req_data  input  N*DSIZE  word of requester i at bits [i*DSIZE +: DSIZE].
- req_last  input  N  word of requester i is the last of its packet.
- req_ready  output  N  one-hot or zero; word of requester i accepted this cycle.
- full  input  1  FIFO write-full flag.
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- gnt_valid  output  1  a grant is held (registered).
- gnt_id  output  IDW  index of the granted requester (registered).

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, rr_ptr=0, cnt=0, gnt_id=0, gnt_valid=0.
  - winc=0 and req_ready=0 immediately, since both are combinational from gnt_valid.
  - A partially sent burst is abandoned; the requester keeps its data.
- States: IDLE, BURST (encoding in package).
- IDLE:
  - If any req_valid, grant the first valid index searching rr_ptr, rr_ptr+1, ... mod N.
  - Next cycle: state=BURST, gnt_id=that index, gnt_valid=1, cnt=0.
  - If none valid, stay in IDLE.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
- BURST, define acc = req_valid[gnt_id] && !full:
  - winc = acc; wdata = req_data[gnt_id]; req_ready[gnt_id] = acc. All other ready bits are 0.
  - If acc, cnt++.
  - Release when any of:
    - acc && req_last[gnt_id]
    - acc && cnt==BURST-1
    - !req_valid[gnt_id] (requester idle for one cycle)
  - On release (next edge): state=IDLE, gnt_valid=0, cnt=0, rr_ptr=(gnt_id+1) mod N.
  - One-cycle bubble between grants (IDLE arbitration cycle). Max sustained throughput is BURST/(BURST+1).
- full high in BURST:
  - winc=0, req_ready=0, cnt holds, grant held indefinitely.
  - No release from full alone; the requester keeps valid asserted.
- Simultaneous events:
  - If last and cnt==BURST-1 fall on the same word, there is a single release.
  - A requester asserting valid in the release cycle is considered in the following IDLE cycle.
- The requester must hold req_data/req_last stable while valid && !ready (standard valid/ready). The arbiter never drops or duplicates a word.
- Width rules:
  - cnt is clog2(BURST+1) bits and never exceeds BURST-1.
  - rr_ptr wrap uses explicit compare to N-1, not power-of-2 truncation.
- Never a write while full; winc is 0 whenever full=1.

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, BURST); localparam for cnt width; helper function for the mod-N increment.
- One sub-module, rr_pick: combinational N-bit round-robin priority picker taking req and rr_ptr, returning found plus index. It is reusable by a future read-side scheduler.

Test Plan (N=4, DSIZE=8, BURST=4, FIFO ASIZE=3):
- Reset release, all req_valid=0 for 10 cycles -> gnt_valid=0, winc=0, req_ready=0 throughout.
- Req 2 alone sends 6 words 0xA0..0xA5, no last:
  - 0xA0..0xA3 written; release; 1 idle cycle; regrant 2.
  - 0xA4, 0xA5 written; FIFO read order A0..A5.
- Reqs 0,1,3 continuously valid, no last -> grant order 0,1,3,0,...; each grant exactly 4 winc pulses separated by one gnt_valid=0 cycle.
- Req 1 sends 2 words with req_last on the 2nd -> release after 2 writes; rr_ptr=2; req 3 pending is granted next ahead of req 0.
- Reader stopped, req 0 streams 12 words:
  - Writes stop at 8 when full=1; winc stays 0 while full; req_ready[0]=0; grant held.
  - After the reader drains, words 9..12 follow with no loss or duplication.
- wrst_n pulsed low mid-burst after 2 of 4 words -> winc/req_ready drop asynchronously; after release, state IDLE with rr_ptr=0 and arbitration restarts from index 0.
